// File: rtl/key_hex_entry_ctrl_pkg.sv
// Shared display types and the hex-to-7-segment lookup for the keypad entry path.
// Segment bit order: bit0..6 = a..g, bit7 = decimal point, 1 = lit.
package key_disp_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'h00;
    localparam seg_t SEG_DP    = 8'h80;

    function automatic seg_t hex2seg(input logic [3:0] hex);
        seg_t seg;
        case (hex)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            4'hF: seg = 8'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_hex_entry_ctrl_key_press_detect.sv
// Turns debounced key levels into single press events; when several keys rise
// together only the lowest index is reported, the others are dropped.
module key_press_detect #(
    parameter int KEY_NUM = 16
) (
    input  logic               external_clk,
    input  logic               external_rstn,
    input  logic [KEY_NUM-1:0] i_key,
    output logic               o_valid,
    output logic [3:0]         o_code
);

    logic [KEY_NUM-1:0] r_key_prev;
    logic [KEY_NUM-1:0] w_new;
    logic [3:0]         w_code;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge external_clk or negedge external_rstn) begin
        if (!external_rstn) r_key_prev <= '0;
        else                r_key_prev <= i_key;
    end

    assign w_new = i_key & ~r_key_prev;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        w_code = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (w_new[i]) w_code = 4'(i);
        end
    end

    assign o_valid = |w_new;
    assign o_code  = w_code;

endmodule

// File: rtl/key_hex_entry_ctrl.sv
// Keypad hex entry: shifts accepted key codes into a digit buffer and drives the
// 8-digit display with 7-segment patterns plus a blinking cursor dot.
module key_hex_entry_ctrl
    import key_disp_pkg::*;
#(
    parameter int NUM          = 8,
    parameter int KEY_NUM      = 16,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic                       external_clk,
    input  logic                       external_rstn,
    input  logic [KEY_NUM-1:0]         key_out,
    input  logic                       clr,
    output seg_t [NUM-1:0]             led_in,
    output logic [4*NUM-1:0]           value,
    output logic [$clog2(NUM+1)-1:0]   digit_cnt,
    output logic                       overflow,
    output logic                       press_pulse,
    output logic [3:0]                 press_code
);

    localparam int CNT_W   = $clog2(NUM + 1);
    localparam int BLINK_W = $clog2(BLINK_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(NUM);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic                 w_valid;
    logic [3:0]           w_code;
    logic                 w_accept;

    logic [4*NUM-1:0]     r_value,     w_value_nxt;
    logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
    logic                 r_overflow,  w_overflow_nxt;
    logic [BLINK_W-1:0]   r_blink_cnt, w_blink_cnt_nxt;
    logic                 r_phase,     w_phase_nxt;
    logic                 r_press_pulse;
    logic [3:0]           r_press_code;
    seg_t [NUM-1:0]       r_led,       w_led_nxt;

    key_press_detect #(
        .KEY_NUM (KEY_NUM)
    ) u_key_press_detect (
        .external_clk  (external_clk),
        .external_rstn (external_rstn),
        .i_key         (key_out),
        .o_valid       (w_valid),
        .o_code        (w_code)
    );

    // A clear in the same cycle swallows the press entirely.
    assign w_accept = w_valid & ~clr;

    // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        w_value_nxt    = r_value;
        w_cnt_nxt      = r_cnt;
        w_overflow_nxt = r_overflow;
        if (clr) begin
            w_value_nxt    = '0;
            w_cnt_nxt      = '0;
            w_overflow_nxt = 1'b0;
        end else if (w_accept) begin
            w_value_nxt = {r_value[4*NUM-5:0], w_code};
            if (r_cnt == CNT_FULL) w_overflow_nxt = 1'b1;
            else                   w_cnt_nxt      = r_cnt + CNT_W'(1);
        end
    end

    // Cursor blink: any accept or clear restarts the period with the dot lit.
    always_comb begin
        w_blink_cnt_nxt = r_blink_cnt + BLINK_W'(1);
        w_phase_nxt     = r_phase;
        if (clr || w_accept) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = ~r_phase;
        end
    end

    // Display is built from next-state values so it changes on the same edge as value/digit_cnt.
    always_comb begin
        w_led_nxt = '0;
        for (int k = 0; k < NUM; k++) begin
            if (k < int'(w_cnt_nxt))
                w_led_nxt[k] = hex2seg(w_value_nxt[4*k +: 4]);
            else if (k == int'(w_cnt_nxt) && w_phase_nxt)
                w_led_nxt[k] = SEG_DP;
            else
                w_led_nxt[k] = SEG_BLANK;
        end
    end

    // NOTE: asynchronous active-low reset clears every register, including the display image.
    always_ff @(posedge external_clk or negedge external_rstn) begin
        if (!external_rstn) begin
            r_value       <= '0;
            r_cnt         <= '0;
            r_overflow    <= 1'b0;
            r_blink_cnt   <= '0;
            r_phase       <= 1'b1;
            r_press_pulse <= 1'b0;
            r_press_code  <= '0;
            r_led         <= '0;
        end else begin
            r_value       <= w_value_nxt;
            r_cnt         <= w_cnt_nxt;
            r_overflow    <= w_overflow_nxt;
            r_blink_cnt   <= w_blink_cnt_nxt;
            r_phase       <= w_phase_nxt;
            r_press_pulse <= w_accept;
            if (w_accept) r_press_code <= w_code;
            r_led         <= w_led_nxt;
        end
    end

    assign led_in      = r_led;
    assign value       = r_value;
    assign digit_cnt   = r_cnt;
    assign overflow    = r_overflow;
    assign press_pulse = r_press_pulse;
    assign press_code  = r_press_code;

endmodule
